// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM generator sharing one prescaled period counter.
//
// Register map (writes only, unmapped addresses ignored):
//   0x00       OUT_EN[CHANNELS-1:0]  output enable per channel
//   0x01       PWM_EN[CHANNELS-1:0]  PWM mode per channel (else static high)
//   0x02       PRESCALE[PRESC_W-1:0] counter advances every PRESCALE+1 clocks
//   0x10+i     DUTY[i][DUTY_W-1:0]   duty cycle of channel i (i < CHANNELS)
//
// Write handshake: wr_en is a single-cycle strobe with no back-pressure; a
// write lands in its register on the same rising edge that samples wr_en=1,
// and writes on consecutive cycles are all accepted.
//
// Optional feature: define PWM_BANK_SHADOW_EN to add per-channel duty shadow
// registers that reload only at period wrap, so duty changes never produce a
// runt pulse. Without it a duty write affects the output on the next edge.
module pwm_bank #(
  parameter int CHANNELS = 8,
  parameter int DUTY_W   = 8,
  parameter int PRESC_W  = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [5:0]          wr_addr,
  input  logic [15:0]         wr_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  // MAX is the all-ones duty value; the counter runs 0..MAX-1.
  localparam logic [DUTY_W-1:0] MAX_V    = {DUTY_W{1'b1}};
  localparam logic [DUTY_W-1:0] CNT_LAST = {{(DUTY_W-1){1'b1}}, 1'b0};

  localparam logic [5:0] ADDR_OUT_EN   = 6'h00;
  localparam logic [5:0] ADDR_PWM_EN   = 6'h01;
  localparam logic [5:0] ADDR_PRESCALE = 6'h02;
  localparam int         ADDR_DUTY0    = 16;

  // Configuration registers
  logic [CHANNELS-1:0] out_en;
  logic [CHANNELS-1:0] pwm_en;
  logic [PRESC_W-1:0]  prescale;
  logic [DUTY_W-1:0]   duty     [CHANNELS];
  logic [DUTY_W-1:0]   duty_act [CHANNELS];

  // Timebase
  logic [PRESC_W-1:0]  pc;
  logic [DUTY_W-1:0]   cnt;
  logic                tick;
  logic                wrap;

  // Write decode strobes
  logic                we_out_en;
  logic                we_pwm_en;
  logic                we_presc;
  logic [CHANNELS-1:0] we_duty;

  // Next-state of the channel outputs
  logic [CHANNELS-1:0] pwm_nxt;

  // Upper write-data bits beyond each register's width are intentionally
  // dropped; fold them into one sink so the whole bus is consumed.
  logic unused_wr_data;
  assign unused_wr_data = ^wr_data;

  // Decode the write strobe into one enable per register.
  always_comb begin
    we_out_en = wr_en && (wr_addr == ADDR_OUT_EN);
    we_pwm_en = wr_en && (wr_addr == ADDR_PWM_EN);
    we_presc  = wr_en && (wr_addr == ADDR_PRESCALE);
    we_duty   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      we_duty[i] = wr_en && (wr_addr == 6'(ADDR_DUTY0 + i));
    end
  end

  // Enable and prescale registers; reset wins over any write.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_en   <= '0;
      pwm_en   <= '0;
      prescale <= '0;
    end else begin
      if (we_out_en) out_en   <= wr_data[CHANNELS-1:0];
      if (we_pwm_en) pwm_en   <= wr_data[CHANNELS-1:0];
      if (we_presc)  prescale <= wr_data[PRESC_W-1:0];
    end
  end

  // Per-channel duty registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        duty[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (we_duty[i]) duty[i] <= wr_data[DUTY_W-1:0];
      end
    end
  end

  // A >= compare (not ==) so that lowering PRESCALE below the running pc
  // forces an immediate tick instead of waiting for pc to roll over.
  assign tick = (pc >= prescale);
  assign wrap = tick && (cnt == CNT_LAST);

  // Prescaler and period counter; cnt wraps from MAX-1 to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= '0;
      cnt <= '0;
    end else if (tick) begin
      pc  <= '0;
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end else begin
      pc  <= pc + 1'b1;
    end
  end

`ifdef PWM_BANK_SHADOW_EN
  logic [DUTY_W-1:0] duty_sh [CHANNELS];

  // Shadow reload at period wrap uses the pre-edge DUTY value, so a write on
  // the wrap edge itself waits for the following wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        duty_sh[i] <= '0;
      end
    end else if (wrap) begin
      for (int i = 0; i < CHANNELS; i++) begin
        duty_sh[i] <= duty[i];
      end
    end
  end

  // Compare against the shadowed duty.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      duty_act[i] = duty_sh[i];
    end
  end
`else
  // Compare directly against the live duty register.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      duty_act[i] = duty[i];
    end
  end
`endif

  // Channel output function: disabled low, static high, or duty compare with
  // duty==MAX forced fully high (cnt never reaches MAX).
  always_comb begin
    pwm_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!out_en[i]) begin
        pwm_nxt[i] = 1'b0;
      end else if (!pwm_en[i]) begin
        pwm_nxt[i] = 1'b1;
      end else if (duty_act[i] == MAX_V) begin
        pwm_nxt[i] = 1'b1;
      end else begin
        pwm_nxt[i] = (cnt < duty_act[i]);
      end
    end
  end

  // Registered outputs; period_start marks the cycle cnt is 0 after a wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= pwm_nxt;
      period_start <= wrap;
    end
  end

endmodule

// File: doc/pwm_bank.md
# pwm_bank

Parametrised multi-channel PWM generator for the TinyTapeout onboarding datapath. It is the generalised successor of the fixed 8-channel, 8-bit PWM peripheral. It sits behind the SPI register-write front end and drives `uo_out`/`uio_out`. All channels share one prescaled period counter, and each channel has its own enables and duty cycle.

## Interface

Parameters:
- `CHANNELS`, default 8: number of PWM outputs, legal range 1..16.
- `DUTY_W`, default 8: duty and counter width in bits, legal range 2..16.
- `PRESC_W`, default 12: prescaler register width in bits, legal range 1..16.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous and active-high.
- `wr_en` input 1: register write strobe, one cycle per write, always accepted.
- `wr_addr` input 6: register address.
- `wr_data` input 16: write data; the LSBs are used and excess bits are ignored.
- `pwm_out` output CHANNELS: registered channel outputs.
- `period_start` output 1: registered one-cycle pulse marking the start of each PWM period.

## Operation

Register map (unmapped addresses are ignored):
- `0x00` `OUT_EN[CHANNELS-1:0]`: output enable.
- `0x01` `PWM_EN[CHANNELS-1:0]`: PWM mode.
- `0x02` `PRESCALE[PRESC_W-1:0]`: counter advances once every `PRESCALE+1` clocks.
- `0x10+i` `DUTY[i][DUTY_W-1:0]`, for i < CHANNELS; addresses `0x10+i` with i ≥ CHANNELS are ignored.

Timebase:
- Prescaler `pc` counts up each clock.
- `tick` = (`pc` ≥ `PRESCALE`). On a tick `pc` returns to 0.
- If `PRESCALE` is lowered below `pc`, the ≥ compare forces a tick and `pc` returns to 0 on the next edge.
- `MAX` = 2^DUTY_W − 1.
- Period counter `cnt` advances on each tick through 0..MAX−1, wrapping from MAX−1 to 0.
- `wrap` = tick AND (`cnt` == MAX−1).

Channel i output:
- `OUT_EN[i]`=0: output 0.
- `OUT_EN[i]`=1, `PWM_EN[i]`=0: output 1 (static).
- Both enables set: output `duty_act[i]`==MAX ? 1 : (`cnt` < `duty_act[i]`).
- Result: duty 0 gives constant low, duty MAX gives constant high, and otherwise the output is high for `duty` of MAX ticks.

`duty_act[i]`:
- Equals `DUTY[i]`, or its shadow copy (see Configuration).

Writes:
- A write takes effect in the register on the edge where `wr_en`=1.
- A write and a wrap in the same cycle are both honoured.
- Back-to-back writes on consecutive cycles are legal.

## Timing

Reset:
- All registers, `pc`, `cnt`, shadows, `pwm_out` and `period_start` go to 0 on the first edge with `rst`=1.
- While `rst` is held, every write is ignored.
- Asserting `rst` mid-period forces all outputs low on the next edge.
- After `rst` falls, counting restarts from `cnt`=0.

Latency:
- `pwm_out` at edge t+1 reflects `cnt`, enables and `duty_act` as they stood during cycle t.
- Consequently a write to OUT_EN/PWM_EN at edge t is visible on `pwm_out` at edge t+1.

`period_start`:
- Registered from `wrap`, so it is high for the one cycle in which `cnt` is 0 after wrapping.
- It is not asserted after reset until the first wrap occurs.

Period:
- Period length is (PRESCALE+1)·MAX clocks.
- The high time is (PRESCALE+1)·duty clocks.

## Configuration

Macro `PWM_BANK_SHADOW_EN`:
- Defined:
  - Each channel has a shadow `duty_sh[i]`, reset to 0, and `duty_act[i]` = `duty_sh[i]`.
  - On a wrap edge, `duty_sh[i]` loads the pre-edge value of `DUTY[i]`.
  - A DUTY write on that same edge lands in `DUTY[i]` and reaches the output only at the following wrap.
  - Duty changes never produce a runt pulse.
- Undefined:
  - No shadow registers; `duty_act[i]` = `DUTY[i]` directly.
  - A new duty reaches `pwm_out` one edge after the write, mid-period.

## Test plan

Bench configuration: CHANNELS=8, DUTY_W=8, PRESC_W=12.

- Reset: hold `rst` for 5 cycles with random writes → `pwm_out`=0x00, `period_start`=0, and all registers read back as 0 via their effect on outputs.
- Static enable: OUT_EN=0x05, PWM_EN=0x00 → `pwm_out`=0x05 one edge later and steady; channel 1 stays 0.
- Duty check: OUT_EN=PWM_EN=0x01, PRESCALE=0, DUTY0=0x80 → `pwm_out[0]` period 255 clocks, high for 128 clocks; `period_start` every 255 clocks. Then DUTY0=0xFF → constant 1, and DUTY0=0x00 → constant 0.
- Prescaler: PRESCALE=3, DUTY0=0x40 → period 1020 clocks, high 256 clocks. Then writing PRESCALE=0 while `pc`=2 → a tick on the next edge and 1-clock ticks thereafter.
- Shadow: DUTY0=0x20 steady, then write DUTY0=0xC0 at `cnt`=0x50.
  - With `PWM_BANK_SHADOW_EN`: the current period keeps a 32-tick high time, and 192 ticks applies from the next `period_start`.
  - Without it: `pwm_out[0]` rises one edge after the write.
- Mid-operation reset: assert `rst` at `cnt`=0x70 with DUTY0=0x80 → outputs 0 on the next edge. After release, registers are 0 and `pwm_out` stays 0 until reprogrammed.
